// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// State encodings are fixed because they are exported on state_o.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam int LOL_CNT_W = 16;

   // The timer only ever compares against (cycles - 1), so clog2 of the
   // largest cycle count is enough bits.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
// Clears to 0 so a stale lock indication never survives reset.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the async level through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= '0;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer running on the PLL refclk.
// Holds the system in reset until lock is stable, re-sequences on loss.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = 1000,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int LOCK_STABLE_CYCLES  = 10000,
   parameter int MAX_RETRIES         = 3,
   parameter int SYNC_STAGES         = 2
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 locked_i,
   input  logic                 force_relock_i,
   output logic                 pll_rst_o,
   output logic                 sys_rst_o,
   output logic                 ready_o,
   output logic                 fault_o,
   output logic [3:0]           retry_count_o,
   output logic [LOL_CNT_W-1:0] lol_count_o,
   output logic [2:0]           state_o
);

   localparam int TW = timer_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                   LOCK_STABLE_CYCLES);

   localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

   state_t        state;
   logic [TW-1:0] timer;
   logic          locked_s;
   logic [3:0]    retry_next;

   sync_bit #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(refclk),
      .rst(rst),
      .d  (locked_i),
      .q  (locked_s)
   );

   assign retry_next = retry_count_o + 4'd1;
   assign state_o    = state;

   // Sequencer FSM; every output is a register updated alongside state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state         <= S_RESET;
         timer         <= '0;
         pll_rst_o     <= 1'b1;
         sys_rst_o     <= 1'b1;
         ready_o       <= 1'b0;
         fault_o       <= 1'b0;
         retry_count_o <= '0;
         lol_count_o   <= '0;
      end else if (force_relock_i) begin
         state         <= S_RESET;
         timer         <= '0;
         pll_rst_o     <= 1'b1;
         sys_rst_o     <= 1'b1;
         ready_o       <= 1'b0;
         fault_o       <= 1'b0;
         retry_count_o <= '0;
      end else begin
         case (state)
            S_RESET: begin
               if (timer == HOLD_LAST) begin
                  state     <= S_WAIT_LOCK;
                  timer     <= '0;
                  pll_rst_o <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               if (locked_s) begin
                  state <= S_STABLE;
                  timer <= '0;
               end else if (timer == TIMEOUT_LAST) begin
                  retry_count_o <= retry_next;
                  timer         <= '0;
                  pll_rst_o     <= 1'b1;
                  if (retry_next == RETRY_MAX) begin
                     state   <= S_FAULT;
                     fault_o <= 1'b1;
                  end else begin
                     state <= S_RESET;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_STABLE: begin
               if (!locked_s) begin
                  state <= S_WAIT_LOCK;
                  timer <= '0;
               end else if (timer == STABLE_LAST) begin
                  state         <= S_RUN;
                  timer         <= '0;
                  sys_rst_o     <= 1'b0;
                  ready_o       <= 1'b1;
                  retry_count_o <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  state     <= S_RESET;
                  timer     <= '0;
                  pll_rst_o <= 1'b1;
                  sys_rst_o <= 1'b1;
                  ready_o   <= 1'b0;
                  if (lol_count_o != '1)
                     lol_count_o <= lol_count_o + 1'b1;
               end
            end
            S_FAULT: begin
               pll_rst_o <= 1'b1;
               sys_rst_o <= 1'b1;
               ready_o   <= 1'b0;
               fault_o   <= 1'b1;
            end
            default: begin
               state <= S_RESET;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened cycle parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pll_lock_sequencer;

   logic        refclk;
   logic        rst;
   logic        locked_i;
   logic        force_relock_i;
   logic        pll_rst_o;
   logic        sys_rst_o;
   logic        ready_o;
   logic        fault_o;
   logic [3:0]  retry_count_o;
   logic [15:0] lol_count_o;
   logic [2:0]  state_o;

   int errors = 0;
   int checks = 0;
   int n;
   int stuck;

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES(20),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2),
      .SYNC_STAGES        (2)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .locked_i      (locked_i),
      .force_relock_i(force_relock_i),
      .pll_rst_o     (pll_rst_o),
      .sys_rst_o     (sys_rst_o),
      .ready_o       (ready_o),
      .fault_o       (fault_o),
      .retry_count_o (retry_count_o),
      .lol_count_o   (lol_count_o),
      .state_o       (state_o)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pll_rst"}, 32'(pll_rst_o), 32'd1);
      check({tag, "_sys_rst"}, 32'(sys_rst_o), 32'd1);
      check({tag, "_ready"}, 32'(ready_o), 32'd0);
      check({tag, "_fault"}, 32'(fault_o), 32'd0);
      check({tag, "_retry"}, 32'(retry_count_o), 32'd0);
      check({tag, "_lol"}, 32'(lol_count_o), 32'd0);
      check({tag, "_state"}, 32'(state_o), 32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      locked_i       = 1'b0;
      force_relock_i = 1'b0;
      tick(); tick(); tick();
      check_reset_vals("por");

      // Normal lock
      rst = 1'b0;
      n = 0;
      while (pll_rst_o === 1'b1 && n < 50) begin tick(); n++; end
      check("hold_len", 32'(n), 32'd4);
      repeat (5) tick();
      check("wait_state", 32'(state_o), 32'd1);
      locked_i = 1'b1;
      n = 0;
      while (ready_o !== 1'b1 && n < 50) begin tick(); n++; end
      check("lock_latency_ok", 32'(n >= 10 && n <= 12), 32'd1);
      check("run_sys_rst", 32'(sys_rst_o), 32'd0);
      check("run_state", 32'(state_o), 32'd3);
      check("run_retry", 32'(retry_count_o), 32'd0);

      // Loss of lock in S_RUN
      locked_i = 1'b0;
      n = 0;
      while (sys_rst_o !== 1'b1 && n < 10) begin tick(); n++; end
      check("lol_react_ok", 32'(n <= 3), 32'd1);
      check("lol_ready", 32'(ready_o), 32'd0);
      check("lol_count", 32'(lol_count_o), 32'd1);
      check("lol_state", 32'(state_o), 32'd0);
      check("lol_pll_rst", 32'(pll_rst_o), 32'd1);
      n = 0;
      while (pll_rst_o === 1'b1 && n < 50) begin tick(); n++; end
      check("lol_hold_len", 32'(n), 32'd4);

      // Relock with a glitch during qualification
      locked_i = 1'b1;
      n = 0;
      while (state_o !== 3'd2 && n < 50) begin tick(); n++; end
      check("gl_enter_stable", 32'(n), 32'd3);
      repeat (4) tick();
      locked_i = 1'b0;
      repeat (3) tick();
      check("gl_back_wait", 32'(state_o), 32'd1);
      check("gl_no_ready", 32'(ready_o), 32'd0);
      locked_i = 1'b1;
      n = 0;
      while (state_o !== 3'd2 && n < 50) begin tick(); n++; end
      check("gl_reenter", 32'(n), 32'd3);
      n = 0;
      while (ready_o !== 1'b1 && n < 50) begin tick(); n++; end
      check("gl_requal_len", 32'(n), 32'd8);
      check("gl_retry", 32'(retry_count_o), 32'd0);
      check("gl_lol", 32'(lol_count_o), 32'd1);

      // force_relock coinciding with loss of lock in S_RUN
      locked_i = 1'b0;
      tick(); tick();
      force_relock_i = 1'b1;
      tick();
      force_relock_i = 1'b0;
      check("frc_run_state", 32'(state_o), 32'd0);
      check("frc_run_lol", 32'(lol_count_o), 32'd1);
      check("frc_run_sys_rst", 32'(sys_rst_o), 32'd1);
      check("frc_run_ready", 32'(ready_o), 32'd0);

      // Never locks: two full attempts then fault
      n = 0;
      while (fault_o !== 1'b1 && n < 200) begin tick(); n++; end
      check("flt_cycles", 32'(n), 32'd48);
      check("flt_pll_rst", 32'(pll_rst_o), 32'd1);
      check("flt_retry", 32'(retry_count_o), 32'd2);
      check("flt_state", 32'(state_o), 32'd4);
      check("flt_sys_rst", 32'(sys_rst_o), 32'd1);
      stuck = 1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (state_o !== 3'd4 || fault_o !== 1'b1) stuck = 0;
      end
      check("flt_stays", 32'(stuck), 32'd1);

      // force_relock out of S_FAULT
      force_relock_i = 1'b1;
      tick();
      force_relock_i = 1'b0;
      check("frc_flt_fault", 32'(fault_o), 32'd0);
      check("frc_flt_retry", 32'(retry_count_o), 32'd0);
      check("frc_flt_state", 32'(state_o), 32'd0);
      check("frc_flt_pll_rst", 32'(pll_rst_o), 32'd1);

      // Async rst in the middle of S_STABLE
      locked_i = 1'b1;
      n = 0;
      while (state_o !== 3'd2 && n < 50) begin tick(); n++; end
      check("ar_in_stable", 32'(state_o), 32'd2);
      repeat (3) tick();
      #3 rst = 1'b1;
      #1;
      check_reset_vals("ar");
      tick(); tick();
      rst = 1'b0;
      n = 0;
      while (pll_rst_o === 1'b1 && n < 50) begin tick(); n++; end
      check("ar_hold_len", 32'(n), 32'd4);
      n = 0;
      while (ready_o !== 1'b1 && n < 50) begin tick(); n++; end
      check("ar_relock_len", 32'(n), 32'd9);
      check("ar_run_state", 32'(state_o), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
